// File: rtl/ct_f_spsram_2048x32_ctrl.sv
// Request/response access controller in front of the 2048x32 single-port SRAM wrapper.
// Define CT_SPSRAM_CTRL_INIT_CLR_EN to zero-fill the whole array after every reset.
module ct_f_spsram_2048x32_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                             forever_cpuclk,
   input  logic                             cpurst_b,
   input  logic                             req_vld,
   output logic                             req_rdy,
   input  logic                             req_wr,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_bmask,
   output logic                             rsp_vld,
   input  logic                             rsp_rdy,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             init_done,
   output logic [ADDR_WIDTH-1:0]            sram_a,
   output logic                             sram_cen,
   output logic                             sram_gwen,
   output logic [DATA_WIDTH-1:0]            sram_wen,
   output logic [DATA_WIDTH-1:0]            sram_d,
   input  logic [DATA_WIDTH-1:0]            sram_q
);

   localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

`ifdef CT_SPSRAM_CTRL_INIT_CLR_EN
   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
   localparam state_t RESET_STATE = ST_INIT;
`else
   typedef enum logic {ST_RUN = 1'b1} state_t;
   localparam state_t RESET_STATE = ST_RUN;
`endif

   state_t                  r_state;
   state_t                  w_stateNext;
   logic [1:0]              r_cnt;
   logic                    r_rdPtr;
   logic                    r_wrPtr;
   logic                    r_rdPend;
   logic [DATA_WIDTH-1:0]   r_mem [2];
   logic                    w_run;
   logic                    w_accept;
   logic                    w_push;
   logic                    w_pop;
   logic [2:0]              w_credit;
`ifdef CT_SPSRAM_CTRL_INIT_CLR_EN
   logic [ADDR_WIDTH-1:0]   r_clrCnt;
`endif

   // Every externally visible handshake is forced idle while reset is held.
   assign w_run     = cpurst_b && (r_state == ST_RUN);
   assign init_done = w_run;
   assign rsp_vld   = cpurst_b && (r_cnt != 2'd0);
   assign rsp_rdata = r_mem[r_rdPtr];
   assign w_pop     = rsp_vld && rsp_rdy;
   assign w_push    = r_rdPend;
   assign w_credit  = {1'b0, r_cnt} + {2'b00, r_rdPend} - {2'b00, w_pop};
   assign req_rdy   = w_run && (w_credit < 3'd2);
   assign w_accept  = req_vld && req_rdy;

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) r_state <= RESET_STATE;
      else           r_state <= w_stateNext;
   end

`ifdef CT_SPSRAM_CTRL_INIT_CLR_EN
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b)                r_clrCnt <= '0;
      else if (r_state == ST_INIT)  r_clrCnt <= r_clrCnt + 1'b1;
   end
`endif

   always_comb begin
      w_stateNext = r_state;
      sram_cen    = 1'b1;
      sram_gwen   = 1'b1;
      sram_wen    = '1;
      sram_a      = req_addr;
      sram_d      = req_wdata;
      case (r_state)
`ifdef CT_SPSRAM_CTRL_INIT_CLR_EN
         ST_INIT: begin
            if (cpurst_b) begin
               sram_cen  = 1'b0;
               sram_gwen = 1'b0;
               sram_wen  = '0;
               sram_a    = r_clrCnt;
               sram_d    = '0;
            end
            if (r_clrCnt == '1) w_stateNext = ST_RUN;
         end
`endif
         ST_RUN: begin
            if (w_accept) begin
               sram_cen = 1'b0;
               if (req_wr) begin
                  sram_gwen = 1'b0;
                  for (int k = 0; k < NUM_LANES; k++) begin
                     sram_wen[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{!req_bmask[k]}};
                  end
               end
            end
         end
         default: w_stateNext = RESET_STATE;
      endcase
   end

   // Q is registered by the SRAM, so it is captured one cycle after the read accept.
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         r_rdPend <= 1'b0;
         r_cnt    <= 2'd0;
         r_rdPtr  <= 1'b0;
         r_wrPtr  <= 1'b0;
      end else begin
         r_rdPend <= w_accept && !req_wr;
         r_cnt    <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_push) r_wrPtr <= ~r_wrPtr;
         if (w_pop)  r_rdPtr <= ~r_rdPtr;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (w_push) r_mem[r_wrPtr] <= sram_q;
   end

   assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
                    !(w_push && !w_pop && (r_cnt == 2'd2)));

endmodule
